dict_mtf_ctrl: RTL and testbench
================================

DICT_MTF_CTRL -- requirements
Module: dict_mtf_ctrl

Interface
REQ-001 Parameter DICT_ENTRY, default 16, is the number of dictionary entries (power of two, at least 4).
REQ-002 Parameter DICT_WORD, default 32, is the width of one dictionary entry in bits.
REQ-003 i_clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 i_rst_n  input  1  asynchronous active-low reset.
REQ-005 i_valid  input  1  match-result request is valid.
REQ-006 o_ready  output  1  block accepts a request this cycle.
REQ-007 i_word  input  DICT_WORD  input word that was searched.
REQ-008 i_type_matched  input  2  search result: 00 miss, 01 partial match, 10 full match, 11 reserved.
REQ-009 i_location  input  $clog2(DICT_ENTRY)  index of the full-match entry.
REQ-010 i_clear  input  1  request to flush the whole dictionary.
REQ-011 o_dict  output  DICT_ENTRY*DICT_WORD  dictionary contents; entry k occupies bits [k*DICT_WORD +: DICT_WORD], entry 0 is most recent.
REQ-012 o_valid_mask  output  DICT_ENTRY  bit k high when entry k holds valid data.
REQ-013 o_count  output  $clog2(DICT_ENTRY)+1  number of valid entries.
REQ-014 o_done  output  1  one-cycle pulse when an update completes.
REQ-015 o_err  output  1  sticky flag for an illegal request.

Function
REQ-016 FSM states: IDLE, UPDATE, CLEAR. o_ready is high only in IDLE.
REQ-017 A request is accepted on a rising edge with i_valid && o_ready && !i_clear. Accept latches i_word, i_type_matched and i_location, then moves to UPDATE.
REQ-018 On the UPDATE edge the dictionary is written, o_done pulses high for that following cycle, and the FSM returns to IDLE, so throughput is one request per 2 cycles.
REQ-019 Full match at location L (L < o_count): entry L moves to entry 0, entries 0..L-1 shift to 1..L, entries above L are unchanged, and o_count is unchanged.
REQ-020 Full match with L = 0: the dictionary is unchanged, but o_done still pulses.
REQ-021 Miss or partial match: i_word is inserted at entry 0, entries 0..DICT_ENTRY-2 shift up one, the old last entry is discarded, and o_count increments saturating at DICT_ENTRY.
REQ-022 o_valid_mask is always the thermometer code of o_count: bits below o_count high, all others low.
REQ-023 Full match with L >= o_count, or type 11: the request is handled as a miss (REQ-021) and o_err is set.
REQ-024 i_clear sampled high in IDLE enters CLEAR; it has priority over a simultaneous i_valid, which is not accepted.
REQ-025 i_clear high during UPDATE is latched, and CLEAR is entered directly after UPDATE instead of IDLE.
REQ-026 CLEAR lasts exactly DICT_ENTRY cycles; down-counter c runs DICT_ENTRY-1 to 0, zeroing entry c and clearing mask bit c per cycle.
REQ-027 CLEAR behaviour per cycle:
- o_count = number of still-set mask bits;
- after the last cycle, o_count = 0, o_err = 0, and the FSM returns to IDLE;
- i_valid and i_clear are ignored during CLEAR;
- o_done does not pulse.
REQ-028 o_dict, o_valid_mask, o_count and o_err are registered outputs; o_ready is decoded from state only.

Reset
REQ-029 While i_rst_n = 0 the block shall hold:
- state = IDLE;
- o_dict all zero, o_valid_mask = 0, o_count = 0;
- o_done = 0, o_err = 0, o_ready = 1 (once the state is IDLE);
- latched clear request and CLEAR counter zeroed.
REQ-030 Reset asserted mid-UPDATE or mid-CLEAR aborts the operation immediately with no partial write visible after release.
REQ-031 The first request is accepted on the first rising edge after i_rst_n deasserts.

Verification
REQ-032 Insert 0x11111111, 0x22222222, 0x33333333 as misses -> entries 0..2 = 0x33333333, 0x22222222, 0x11111111; o_count = 3; o_valid_mask = 0x0007; three o_done pulses, each one cycle after its accept.
REQ-033 After REQ-032, full match at L = 2 -> entries 0..2 = 0x11111111, 0x33333333, 0x22222222; o_count = 3.
REQ-034 Apply 17 distinct misses 0x00000001..0x00000011 -> o_count = 16; entry 0 = 0x00000011; entry 15 = 0x00000002; o_valid_mask = 0xFFFF.
REQ-035 With o_count = 3, send full match at L = 9 -> treated as insert; o_count = 4; o_err = 1 and stays 1; then i_clear -> o_ready low for 16 cycles; afterwards o_dict = 0, o_count = 0, o_err = 0.
REQ-036 Simultaneous events:
- i_valid and i_clear both high in IDLE -> CLEAR is taken and the request is not accepted;
- i_clear pulsed during UPDATE -> the update completes with o_done high, then CLEAR begins.
REQ-037 Reset mid-stream:
- assert i_rst_n = 0 during UPDATE -> all outputs return to reset values asynchronously;
- after release, a miss of 0xDEADBEEF gives entry 0 = 0xDEADBEEF and o_count = 1.

Source files
------------

// File: rtl/dict_mtf_ctrl.sv
// -----------------------------------------------------------------------------
// dict_mtf_ctrl
//   Move-to-front dictionary controller. Each accepted search result updates
//   a small dictionary. A full match moves the matched entry to the front.
//   A miss or partial match inserts the searched word at the front and drops
//   the oldest entry. A flush walks the table from the top entry down, zeroing
//   one entry per cycle.
//
// Ports
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_valid/o_ready  request handshake (ready only while idle)
//   i_word           word that was searched
//   i_type_matched   00 miss, 01 partial, 10 full match, 11 reserved
//   i_location       index of the full-match entry
//   i_clear          flush request (wins over a simultaneous i_valid)
//   o_dict           entry k at [k*DICT_WORD +: DICT_WORD], entry 0 most recent
//   o_valid_mask     thermometer code of o_count
//   o_count          number of valid entries
//   o_done           one-cycle pulse after each dictionary update
//   o_err            sticky illegal-request flag, cleared by a flush
// -----------------------------------------------------------------------------
module dict_mtf_ctrl #(
    parameter int DICT_ENTRY = 16,
    parameter int DICT_WORD  = 32
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic                               i_valid,
    output logic                               o_ready,
    input  logic [DICT_WORD-1:0]               i_word,
    input  logic [1:0]                         i_type_matched,
    input  logic [$clog2(DICT_ENTRY)-1:0]      i_location,
    input  logic                               i_clear,
    output logic [DICT_ENTRY*DICT_WORD-1:0]    o_dict,
    output logic [DICT_ENTRY-1:0]              o_valid_mask,
    output logic [$clog2(DICT_ENTRY):0]        o_count,
    output logic                               o_done,
    output logic                               o_err
);

    localparam int LOC_W = $clog2(DICT_ENTRY);
    localparam int CNT_W = LOC_W + 1;

    typedef enum logic [1:0] {IDLE, UPDATE, CLEAR} state_t;

    state_t                 state;
    state_t                 next_state;

    logic [DICT_WORD-1:0]   dict     [DICT_ENTRY];
    logic [DICT_WORD-1:0]   upd_dict [DICT_ENTRY];
    logic [DICT_ENTRY-1:0]  mask;
    logic [CNT_W-1:0]       count;
    logic                   done;
    logic                   err;
    logic [LOC_W-1:0]       clr_cnt;

    logic [DICT_WORD-1:0]   word_q;
    logic [1:0]             type_q;
    logic [LOC_W-1:0]       loc_q;
    logic                   hit;

    // Count saturates at a full dictionary.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_W'(DICT_ENTRY)) ? v : v + 1'b1;
    endfunction

    // A full match only counts when it points at a valid entry; anything else
    // falls back to an insert.
    assign hit = (type_q == 2'b10) && ({1'b0, loc_q} < count);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        o_ready    = 1'b0;
        case (state)
            IDLE: begin
                o_ready = 1'b1;
                if (i_clear)      next_state = CLEAR;
                else if (i_valid) next_state = UPDATE;
            end
            UPDATE:  next_state = i_clear ? CLEAR : IDLE;
            CLEAR:   if (clr_cnt == '0) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Next dictionary image for the pending request.
    always_comb begin
        upd_dict = dict;
        if (hit) begin
            // Rotate entries 0..L right by one; entry L lands at the front.
            for (int k = 1; k < DICT_ENTRY; k++) begin
                if (k <= int'(loc_q)) upd_dict[LOC_W'(k)] = dict[LOC_W'(k - 1)];
            end
            upd_dict[0] = dict[loc_q];
        end else begin
            for (int k = 1; k < DICT_ENTRY; k++) begin
                upd_dict[LOC_W'(k)] = dict[LOC_W'(k - 1)];
            end
            upd_dict[0] = word_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < DICT_ENTRY; k++) dict[LOC_W'(k)] <= '0;
            mask    <= '0;
            count   <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
            clr_cnt <= '0;
            word_q  <= '0;
            type_q  <= '0;
            loc_q   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_clear) begin
                        clr_cnt <= LOC_W'(DICT_ENTRY - 1);
                    end else if (i_valid) begin
                        word_q <= i_word;
                        type_q <= i_type_matched;
                        loc_q  <= i_location;
                    end
                end
                UPDATE: begin
                    dict <= upd_dict;
                    done <= 1'b1;
                    if (!hit) begin
                        mask  <= {mask[DICT_ENTRY-2:0], 1'b1};
                        count <= sat_inc(count);
                        // Reaching here with type 1x means a bad location or
                        // the reserved code.
                        if (type_q[1]) err <= 1'b1;
                    end
                    // A clear seen during the update is honoured right after it.
                    if (i_clear) clr_cnt <= LOC_W'(DICT_ENTRY - 1);
                end
                CLEAR: begin
                    dict[clr_cnt] <= '0;
                    mask[clr_cnt] <= 1'b0;
                    // Mask is a thermometer, so the remaining population is
                    // simply min(count, clr_cnt).
                    if (count > {1'b0, clr_cnt}) count <= {1'b0, clr_cnt};
                    if (clr_cnt == '0) err <= 1'b0;
                    else               clr_cnt <= clr_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < DICT_ENTRY; g++) begin : g_dict_out
        assign o_dict[g*DICT_WORD +: DICT_WORD] = dict[g];
    end

    assign o_valid_mask = mask;
    assign o_count      = count;
    assign o_done       = done;
    assign o_err        = err;

endmodule

// File: tb/tb_dict_mtf_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dict_mtf_ctrl
//   Bench for dict_mtf_ctrl. A queue-based reference model tracks the valid
//   dictionary entries. Directed sequences pin literal expectations, then a
//   randomized stream runs with the model compared every cycle.
// -----------------------------------------------------------------------------
module tb_dict_mtf_ctrl;

    localparam int N  = 16;
    localparam int W  = 32;
    localparam int LW = 4;
    localparam int CW = 5;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid = 1'b0;
    logic          clr   = 1'b0;
    logic [W-1:0]  word  = '0;
    logic [1:0]    typ   = '0;
    logic [LW-1:0] loc   = '0;

    logic          ready;
    logic          done;
    logic          err;
    logic [N*W-1:0] dict;
    logic [N-1:0]  mask;
    logic [CW-1:0] count;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [W-1:0] md[$];
    bit           m_err;
    bit           m_done;
    int           m_phase;   // 0 ready, 1 request pending, 2 flushing
    int           m_left;
    logic [W-1:0] p_word;
    logic [1:0]   p_type;
    int           p_loc;

    dict_mtf_ctrl #(.DICT_ENTRY(N), .DICT_WORD(W)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_valid        (valid),
        .o_ready        (ready),
        .i_word         (word),
        .i_type_matched (typ),
        .i_location     (loc),
        .i_clear        (clr),
        .o_dict         (dict),
        .o_valid_mask   (mask),
        .o_count        (count),
        .o_done         (done),
        .o_err          (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] ent(input int k);
        return dict[k*W +: W];
    endfunction

    function automatic logic [N*W-1:0] model_dict();
        logic [N*W-1:0] r = '0;
        for (int k = 0; k < md.size(); k++) r[k*W +: W] = md[k];
        return r;
    endfunction

    function automatic logic [N-1:0] model_mask();
        logic [N-1:0] r = '0;
        for (int k = 0; k < md.size(); k++) r[k] = 1'b1;
        return r;
    endfunction

    task automatic cmp_all();
        chk("ready", ready, (m_phase == 0));
        chk("done",  done,  m_done);
        chk("count", count, md.size());
        chk("mask",  mask,  model_mask());
        chk("err",   err,   m_err);
        chk("dict",  dict,  model_dict());
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("ready_timeout", ready, 1);
    endtask

    task automatic send(input logic [W-1:0] w, input logic [1:0] t, input int l, input bit clr_upd);
        wait_ready();
        valid = 1'b1;
        word  = w;
        typ   = t;
        loc   = LW'(l);
        @(negedge clk);
        valid = 1'b0;
        clr   = clr_upd;
        @(negedge clk);
        clr   = 1'b0;
        chk("done_after_accept", done, 1);
    endtask

    task automatic model_step();
        logic [W-1:0] w;
        m_done = 0;
        case (m_phase)
            0: begin
                if (clr) begin
                    m_phase = 2;
                    m_left  = N;
                end else if (valid) begin
                    p_word  = word;
                    p_type  = typ;
                    p_loc   = int'(loc);
                    m_phase = 1;
                end
            end
            1: begin
                if (p_type == 2'b10 && p_loc < md.size()) begin
                    w = md[p_loc];
                    md.delete(p_loc);
                    md.push_front(w);
                end else begin
                    md.push_front(p_word);
                    if (md.size() > N) void'(md.pop_back());
                    if (p_type[1]) m_err = 1;
                end
                m_done = 1;
                if (clr) begin
                    m_phase = 2;
                    m_left  = N;
                end else begin
                    m_phase = 0;
                end
            end
            default: begin
                m_left--;
                while (md.size() > m_left) void'(md.pop_back());
                if (m_left == 0) begin
                    m_err   = 0;
                    m_phase = 0;
                end
            end
        endcase
    endtask

    initial begin
        int n;
        int r;
        fork
            forever begin
                @(posedge clk or negedge rst_n);
                if (!rst_n) begin
                    md.delete();
                    m_err   = 0;
                    m_done  = 0;
                    m_phase = 0;
                    m_left  = 0;
                end else begin
                    model_step();
                end
            end
            forever begin
                @(negedge clk);
                cmp_all();
            end
        join_none

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_count", count, 0);
        chk("rst_mask",  mask,  0);
        chk("rst_dict",  dict,  0);
        chk("rst_err",   err,   0);
        chk("rst_done",  done,  0);
        rst_n = 1'b1;

        // three misses, first one on the edge right after release
        send(32'h11111111, 2'b00, 0, 0);
        send(32'h22222222, 2'b01, 0, 0);
        send(32'h33333333, 2'b00, 0, 0);
        chk("ins_e0", ent(0), 32'h33333333);
        chk("ins_e1", ent(1), 32'h22222222);
        chk("ins_e2", ent(2), 32'h11111111);
        chk("ins_cnt", count, 3);
        chk("ins_mask", mask, 16'h0007);

        // full match at L=2
        send(32'hCAFE0000, 2'b10, 2, 0);
        chk("mtf_e0", ent(0), 32'h11111111);
        chk("mtf_e1", ent(1), 32'h33333333);
        chk("mtf_e2", ent(2), 32'h22222222);
        chk("mtf_cnt", count, 3);

        // out-of-range full match becomes an insert and flags an error
        send(32'h99990009, 2'b10, 9, 0);
        chk("bad_e0", ent(0), 32'h99990009);
        chk("bad_cnt", count, 4);
        chk("bad_err", err, 1);
        send(32'h12345678, 2'b00, 0, 0);
        chk("err_sticky", err, 1);
        chk("sticky_cnt", count, 5);

        // flush
        wait_ready();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        n = 0;
        while (!ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("clear_len", n, 16);
        chk("clr_dict", dict, 0);
        chk("clr_cnt", count, 0);
        chk("clr_err", err, 0);

        // 17 misses saturate the count
        for (int i = 1; i <= 17; i++) send(W'(i), 2'b00, 0, 0);
        chk("sat_cnt", count, 16);
        chk("sat_e0", ent(0), 32'h00000011);
        chk("sat_e15", ent(15), 32'h00000002);
        chk("sat_mask", mask, 16'hFFFF);

        // L=0 leaves dictionary alone
        send(32'hFFFFFFFF, 2'b10, 0, 0);
        chk("l0_e0", ent(0), 32'h00000011);
        chk("l0_e1", ent(1), 32'h00000010);
        chk("l0_cnt", count, 16);

        // L=15 on a full table
        send(32'hFFFFFFFF, 2'b10, 15, 0);
        chk("l15_e0", ent(0), 32'h00000002);
        chk("l15_e1", ent(1), 32'h00000011);
        chk("l15_e15", ent(15), 32'h00000003);

        // valid and clear together: clear wins
        wait_ready();
        valid = 1'b1;
        clr   = 1'b1;
        word  = 32'h00000077;
        typ   = 2'b00;
        @(negedge clk);
        valid = 1'b0;
        clr   = 1'b0;
        chk("vc_ready", ready, 0);
        chk("vc_done", done, 0);
        wait_ready();
        chk("vc_cnt", count, 0);
        chk("vc_e0", ent(0), 0);

        // clear during update
        send(32'h0BADF00D, 2'b00, 0, 1);
        chk("cu_ready", ready, 0);
        chk("cu_e0", ent(0), 32'h0BADF00D);
        chk("cu_cnt", count, 1);
        wait_ready();
        chk("cu_cnt_after", count, 0);

        // reset in the middle of an update
        send(32'hAAAAAAAA, 2'b00, 0, 0);
        send(32'hBBBBBBBB, 2'b11, 0, 0);
        chk("pre_rst_err", err, 1);
        wait_ready();
        valid = 1'b1;
        word  = 32'hCCCCCCCC;
        typ   = 2'b00;
        @(negedge clk);
        valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cnt", count, 0);
        chk("arst_dict", dict, 0);
        chk("arst_mask", mask, 0);
        chk("arst_ready", ready, 1);
        chk("arst_done", done, 0);
        chk("arst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        send(32'hDEADBEEF, 2'b00, 0, 0);
        chk("post_e0", ent(0), 32'hDEADBEEF);
        chk("post_e1", ent(1), 0);
        chk("post_cnt", count, 1);

        // randomized stream
        for (int i = 0; i < 2000; i++) begin
            valid = ($urandom_range(99) < 60);
            clr   = ($urandom_range(99) < 3);
            word  = $urandom;
            r     = $urandom_range(99);
            typ   = (r < 35) ? 2'b00 : (r < 55) ? 2'b01 : (r < 95) ? 2'b10 : 2'b11;
            if (typ == 2'b10 && md.size() > 0 && $urandom_range(3) != 0)
                loc = LW'($urandom_range(md.size() - 1));
            else
                loc = LW'($urandom);
            if (i == 700 || i == 1500) begin
                #3 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        valid = 1'b0;
        clr   = 1'b0;
        repeat (20) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
